// File: rtl/pool_stream_engine.sv
// Multi-lane streaming pooling engine: each lane reduces a window of accepted
// samples to one signed max or saturated shifted mean, with valid/ready on both sides.
module pool_stream_engine #(
    parameter int W       = 16,
    parameter int LANES   = 4,
    parameter int MAX_WIN = 16,
    parameter int CW      = $clog2(MAX_WIN + 1),
    parameter int AW      = W + $clog2(MAX_WIN),
    parameter int SW      = $clog2(AW)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               cfg_mode,
    input  logic [CW-1:0]      cfg_win_len,
    input  logic [SW-1:0]      cfg_shift,
    input  logic [LANES-1:0]   cfg_lane_en,
    input  logic               ip_valid,
    output logic               ip_ready,
    input  logic [LANES*W-1:0] ip_data,
    output logic               op_valid,
    input  logic               op_ready,
    output logic [LANES*W-1:0] op_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

    state_t           state, state_next;
    logic             mode_reg;
    logic [CW-1:0]    win_reg;
    logic [SW-1:0]    shift_reg;
    logic [LANES-1:0] lane_en_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    cfg_win_eff;
    logic             accept, start, enter_hold;
    logic             eff_mode;
    logic [SW-1:0]    eff_shift;
    logic [LANES-1:0] eff_en;

    assign accept     = ip_valid && ip_ready;
    assign start      = accept && (state == IDLE);
    assign enter_hold = (state != HOLD) && (state_next == HOLD);

    always_comb begin
        cfg_win_eff = cfg_win_len;
        if (cfg_win_len == '0)
            cfg_win_eff = CW'(1);
        else if (cfg_win_len > CW'(MAX_WIN))
            cfg_win_eff = CW'(MAX_WIN);
    end

    // The window-opening accept uses the live config; later accepts use the captured copy.
    assign eff_mode  = (state == IDLE) ? cfg_mode    : mode_reg;
    assign eff_shift = (state == IDLE) ? cfg_shift   : shift_reg;
    assign eff_en    = (state == IDLE) ? cfg_lane_en : lane_en_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (cfg_win_eff == CW'(1)) ? HOLD : ACCUM;
            ACCUM:   if (accept && (CW'(count_reg + 1'b1) == win_reg)) state_next = HOLD;
            HOLD:    if (op_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ip_ready = 1'b0;
        op_valid = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE:  ip_ready = 1'b1;
            ACCUM: begin
                ip_ready = 1'b1;
                busy     = 1'b1;
            end
            HOLD: begin
                op_valid = 1'b1;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode_reg    <= 1'b0;
            win_reg     <= '0;
            shift_reg   <= '0;
            lane_en_reg <= '0;
            count_reg   <= '0;
        end else begin
            if (start) begin
                mode_reg    <= cfg_mode;
                win_reg     <= cfg_win_eff;
                shift_reg   <= cfg_shift;
                lane_en_reg <= cfg_lane_en;
                count_reg   <= CW'(1);
            end else if (accept) begin
                count_reg <= CW'(count_reg + 1'b1);
            end else if ((state == HOLD) && op_ready) begin
                count_reg <= '0;
            end
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic signed [W-1:0]  s;
        logic signed [AW-1:0] s_ext, acc_reg, acc_next, sh;
        logic        [W-1:0]  res, out_reg;

        assign s     = eff_en[gi] ? ip_data[gi*W +: W] : '0;
        assign s_ext = {{(AW-W){s[W-1]}}, s};
        assign sh    = acc_next >>> eff_shift;

        always_comb begin
            acc_next = acc_reg;
            if (start)
                acc_next = s_ext;
            else if (accept) begin
                if (eff_mode)
                    acc_next = acc_reg + s_ext;
                else if (s_ext > acc_reg)
                    acc_next = s_ext;
            end
        end

        // Result is formed from the post-update accumulator so it can be latched on HOLD entry.
        always_comb begin
            res = acc_next[W-1:0];
            if (eff_mode) begin
                if (sh > SAT_MAX)
                    res = SAT_MAX[W-1:0];
                else if (sh < SAT_MIN)
                    res = SAT_MIN[W-1:0];
                else
                    res = sh[W-1:0];
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                acc_reg <= '0;
                out_reg <= '0;
            end else begin
                acc_reg <= acc_next;
                if (enter_hold)
                    out_reg <= res;
            end
        end

        assign op_data[gi*W +: W] = out_reg;
    end

endmodule

// File: tb/tb_pool_stream_engine.sv
// Randomised self-checking bench for pool_stream_engine against a window-level
// reference model (plain max / sum-shift-saturate over stored sample arrays).
module tb_pool_stream_engine;

    localparam int W       = 16;
    localparam int LANES   = 4;
    localparam int MAX_WIN = 16;
    localparam int CW      = $clog2(MAX_WIN + 1);
    localparam int AW      = W + $clog2(MAX_WIN);
    localparam int SW      = $clog2(AW);

    logic               CLK = 1'b0;
    logic               RST = 1'b1;
    logic               cfg_mode = 1'b0;
    logic [CW-1:0]      cfg_win_len = '0;
    logic [SW-1:0]      cfg_shift = '0;
    logic [LANES-1:0]   cfg_lane_en = '1;
    logic               ip_valid = 1'b0;
    logic               ip_ready;
    logic [LANES*W-1:0] ip_data = '0;
    logic               op_valid;
    logic               op_ready = 1'b0;
    logic [LANES*W-1:0] op_data;
    logic               busy;

    pool_stream_engine #(.W(W), .LANES(LANES), .MAX_WIN(MAX_WIN)) dut (
        .CLK(CLK), .RST(RST), .cfg_mode(cfg_mode), .cfg_win_len(cfg_win_len),
        .cfg_shift(cfg_shift), .cfg_lane_en(cfg_lane_en), .ip_valid(ip_valid),
        .ip_ready(ip_ready), .ip_data(ip_data), .op_valid(op_valid),
        .op_ready(op_ready), .op_data(op_data), .busy(busy)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int samp [MAX_WIN][LANES];
    bit               m_mode;
    int               m_win;
    int               m_shift;
    logic [LANES-1:0] m_en;
    bit               stuck;
    bit               last_valid;
    int               xfer_cyc;

    function automatic int eff_win(input int raw);
        if (raw == 0) return 1;
        if (raw > MAX_WIN) return MAX_WIN;
        return raw;
    endfunction

    // Reference: whole-window reduction over the stored samples.
    function automatic logic [LANES*W-1:0] ref_vec(input bit mode, input int win_raw,
                                                   input int shift, input logic [LANES-1:0] en);
        logic [LANES*W-1:0] r;
        logic [63:0]        vb;
        longint             v, hi, lo;
        int                 n;
        n  = eff_win(win_raw);
        hi = (64'sd1 <<< (W - 1)) - 1;
        lo = -hi - 1;
        r  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (!en[l]) v = 0;
            else if (!mode) begin
                v = samp[0][l];
                for (int k = 1; k < n; k++) if (samp[k][l] > v) v = samp[k][l];
            end else begin
                v = 0;
                for (int k = 0; k < n; k++) v += samp[k][l];
                v = v >>> shift;
                if (v > hi) v = hi;
                if (v < lo) v = lo;
            end
            vb = v;
            r[l*W +: W] = vb[W-1:0];
        end
        return r;
    endfunction

    task automatic set_cfg(input bit mode, input int win, input int shift, input logic [LANES-1:0] en);
        m_mode = mode; m_win = win; m_shift = shift; m_en = en;
        cfg_mode = mode; cfg_win_len = CW'(win); cfg_shift = SW'(shift); cfg_lane_en = en;
    endtask

    task automatic fill_random();
        for (int k = 0; k < MAX_WIN; k++)
            for (int l = 0; l < LANES; l++)
                samp[k][l] = int'($urandom_range(0, 65535)) - 32768;
    endtask

    // Feeds samples 0..n-1; optionally scrambles the live config after the first accept.
    task automatic send_window(input int n, input int gap_pct, input bit flip);
        logic [31:0] t;
        int cnt, g;
        stuck = 1'b0;
        for (int k = 0; k < n; k++) begin
            g = 0;
            while (g < 4 && $urandom_range(0, 99) < gap_pct) begin
                ip_valid = 1'b0;
                ip_data  = {$urandom, $urandom};
                @(posedge CLK); #1;
                g++;
            end
            for (int l = 0; l < LANES; l++) begin
                t = samp[k][l];
                ip_data[l*W +: W] = t[W-1:0];
            end
            ip_valid = 1'b1;
            cnt = 0;
            while (!ip_ready && cnt < 64) begin
                @(posedge CLK); #1;
                cnt++;
            end
            if (!ip_ready) stuck = 1'b1;
            @(posedge CLK); #1;
            if (flip && k == 0) begin
                cfg_mode    = ~cfg_mode;
                cfg_win_len = CW'($urandom_range(0, 31));
                cfg_shift   = SW'($urandom_range(0, 31));
                cfg_lane_en = LANES'($urandom);
            end
        end
        ip_valid   = 1'b0;
        last_valid = op_valid;
    endtask

    task automatic take(input int delay, output logic [LANES*W-1:0] res, output bit ok);
        int cnt;
        ok  = !stuck;
        cnt = 0;
        while (!op_valid && cnt < 64) begin
            @(posedge CLK); #1;
            cnt++;
        end
        if (!op_valid) ok = 1'b0;
        repeat (delay) begin
            @(posedge CLK); #1;
        end
        res = op_data;
        op_ready = 1'b1;
        @(posedge CLK); #1;
        op_ready = 1'b0;
        xfer_cyc = cyc;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (op_valid !== 1'b0 || op_data !== '0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: got valid=%b data=%h busy=%b expected 0/0/0", op_valid, op_data, busy);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        @(posedge CLK); #1;
        tests++;
        if (ip_ready !== 1'b1 || op_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: got ready=%b valid=%b busy=%b expected 1/0/0", ip_ready, op_valid, busy);
        end
    endtask

    task automatic test_max_basic();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        fill_random();
        samp[0][0] = 3; samp[1][0] = -7; samp[2][0] = 12; samp[3][0] = 5;
        set_cfg(1'b0, 4, 0, '1);
        exp = ref_vec(m_mode, m_win, m_shift, m_en);
        send_window(4, 0, 1'b0);
        tests++;
        if (last_valid !== 1'b1 || ip_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL max_latency: got valid=%b ready=%b busy=%b expected 1/0/1", last_valid, ip_ready, busy);
        end
        take(0, res, ok);
        tests++;
        if (!ok || res !== exp || res[W-1:0] !== 16'd12) begin
            fails++;
            $display("FAIL max_basic: got %h expected %h (ok=%b)", res, exp, ok);
        end
    endtask

    task automatic test_signed_max();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int l = 0; l < LANES; l++) begin
            samp[0][l] = -5 - l; samp[1][l] = -2 - l; samp[2][l] = -9 - l;
        end
        set_cfg(1'b0, 3, 0, 4'b1011);
        exp = ref_vec(m_mode, m_win, m_shift, m_en);
        send_window(3, 0, 1'b0);
        take(0, res, ok);
        tests++;
        if (!ok || res !== exp || res[W-1:0] !== 16'hFFFE || res[2*W +: W] !== 16'h0000) begin
            fails++;
            $display("FAIL signed_max: got %h expected %h (ok=%b)", res, exp, ok);
        end
    endtask

    task automatic test_mean();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        fill_random();
        for (int k = 0; k < 4; k++) samp[k][0] = 100 * (k + 1);
        set_cfg(1'b1, 4, 2, '1);
        exp = ref_vec(m_mode, m_win, m_shift, m_en);
        send_window(4, 0, 1'b0);
        take(0, res, ok);
        tests++;
        if (!ok || res !== exp || res[W-1:0] !== 16'd250) begin
            fails++;
            $display("FAIL mean: got %h expected %h (ok=%b)", res, exp, ok);
        end
    endtask

    task automatic test_saturation();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 4; k++)
                for (int l = 0; l < LANES; l++)
                    samp[k][l] = (pass == 0) ? 32767 : -32768;
            set_cfg(1'b1, 4, 0, '1);
            exp = {LANES{(pass == 0) ? 16'h7FFF : 16'h8000}};
            send_window(4, 0, 1'b0);
            take(0, res, ok);
            tests++;
            if (!ok || res !== exp) begin
                fails++;
                $display("FAIL mean_saturation_%0d: got %h expected %h (ok=%b)", pass, res, exp, ok);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [LANES*W-1:0] exp;
        fill_random();
        set_cfg(1'b0, 3, 0, '1);
        exp = ref_vec(m_mode, m_win, m_shift, m_en);
        send_window(3, 0, 1'b0);
        ip_valid = 1'b1;
        ip_data  = {$urandom, $urandom};
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            tests++;
            if (op_valid !== 1'b1 || op_data !== exp || ip_ready !== 1'b0) begin
                fails++;
                $display("FAIL backpressure_hold_%0d: got valid=%b data=%h ready=%b expected 1/%h/0",
                         c, op_valid, op_data, ip_ready, exp);
            end
        end
        ip_valid = 1'b0;
        op_ready = 1'b1;
        @(posedge CLK); #1;
        op_ready = 1'b0;
        tests++;
        if (op_valid !== 1'b0 || ip_ready !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_release: got valid=%b ready=%b expected 0/1", op_valid, ip_ready);
        end
    endtask

    task automatic test_mid_reset();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < LANES; l++)
                samp[k][l] = (k < 2) ? 32767 : -100 * (k + l + 1);
        set_cfg(1'b0, 4, 0, '1);
        send_window(2, 0, 1'b0);
        #2;
        RST = 1'b1;
        #1;
        tests++;
        if (op_valid !== 1'b0 || busy !== 1'b0 || ip_ready !== 1'b1 || op_data !== '0) begin
            fails++;
            $display("FAIL mid_reset_outputs: got valid=%b busy=%b ready=%b data=%h expected 0/0/1/0",
                     op_valid, busy, ip_ready, op_data);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        for (int k = 0; k < 4; k++)
            for (int l = 0; l < LANES; l++)
                samp[k][l] = -100 * (k + l + 1);
        exp = ref_vec(m_mode, m_win, m_shift, m_en);
        send_window(4, 0, 1'b0);
        take(0, res, ok);
        tests++;
        if (!ok || res !== exp) begin
            fails++;
            $display("FAIL mid_reset_next_window: got %h expected %h (ok=%b)", res, exp, ok);
        end
    endtask

    task automatic test_win_zero();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int i = 0; i < 3; i++) begin
            fill_random();
            set_cfg(1'(i), 0, 0, '1);
            exp = ref_vec(m_mode, m_win, m_shift, m_en);
            send_window(1, 0, 1'b0);
            take(0, res, ok);
            tests++;
            if (!ok || last_valid !== 1'b1 || res !== exp) begin
                fails++;
                $display("FAIL win_zero_%0d: got %h valid=%b expected %h valid=1 (ok=%b)",
                         i, res, last_valid, exp, ok);
            end
        end
    endtask

    task automatic test_cfg_change();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            fill_random();
            set_cfg(1'(i), 5, 3, 4'b0111);
            exp = ref_vec(m_mode, m_win, m_shift, m_en);
            send_window(5, 0, 1'b1);
            take(0, res, ok);
            tests++;
            if (!ok || res !== exp) begin
                fails++;
                $display("FAIL cfg_change_%0d: got %h expected %h (ok=%b)", i, res, exp, ok);
            end
        end
    endtask

    task automatic test_gaps();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            fill_random();
            set_cfg(1'(i), 6, 2, '1);
            exp = ref_vec(m_mode, m_win, m_shift, m_en);
            send_window(6, 60, 1'b0);
            take(0, res, ok);
            tests++;
            if (!ok || res !== exp) begin
                fails++;
                $display("FAIL gaps_%0d: got %h expected %h (ok=%b)", i, res, exp, ok);
            end
        end
    endtask

    task automatic test_random();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        for (int i = 0; i < 30; i++) begin
            fill_random();
            set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 20), $urandom_range(0, 8),
                    LANES'($urandom));
            exp = ref_vec(m_mode, m_win, m_shift, m_en);
            send_window(eff_win(m_win), 25, 1'($urandom_range(0, 1)));
            take($urandom_range(0, 3), res, ok);
            tests++;
            if (!ok || res !== exp) begin
                fails++;
                $display("FAIL random_%0d: got %h expected %h (mode=%0d win=%0d shift=%0d en=%b ok=%b)",
                         i, res, exp, m_mode, m_win, m_shift, m_en, ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [LANES*W-1:0] res, exp;
        bit ok;
        int prev;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            fill_random();
            set_cfg(1'b0, 3, 0, '1);
            exp = ref_vec(m_mode, m_win, m_shift, m_en);
            send_window(3, 0, 1'b0);
            take(0, res, ok);
            tests++;
            if (!ok || res !== exp || (i > 0 && xfer_cyc - prev !== 4)) begin
                fails++;
                $display("FAIL back_to_back_%0d: got %h period=%0d expected %h period=4 (ok=%b)",
                         i, res, xfer_cyc - prev, exp, ok);
            end
            prev = xfer_cyc;
        end
    endtask

    initial begin
        test_reset();
        test_max_basic();
        test_signed_max();
        test_mean();
        test_saturation();
        test_backpressure();
        test_mid_reset();
        test_win_zero();
        test_cfg_change();
        test_gaps();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
